// File: rtl/fifo_flex.sv
// Single-clock FIFO: any depth, FWFT or registered read, live count,
// programmable almost flags, sticky error flags and synchronous flush.
module fifo_flex #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter bit FWFT   = 1'b1,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  afull_thr,
  input  logic [CNT_W-1:0]  aempty_thr,
  output logic              almost_full,
  output logic              almost_empty,
  input  logic              flush,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wa;
  logic              ra;

  // Explicit wrap keeps non-power-of-two depths correct
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= afull_thr);
  assign almost_empty = (count <= aempty_thr);

  assign wa = wr_en && !full && !flush;
  assign ra = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wa) wr_ptr <= ptr_inc(wr_ptr);
      if (ra) rd_ptr <= ptr_inc(rd_ptr);
      if (wa && !ra)      count <= count + CNT_W'(1);
      else if (ra && !wa) count <= count - CNT_W'(1);
    end
  end

  // New error beats clr_err in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush) overflow <= 1'b1;
      else if (clr_err)            overflow <= 1'b0;
      if (rd_en && empty && !flush) underflow <= 1'b1;
      else if (clr_err)             underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_q;
    logic              rv_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= ra;
        if (ra) rd_q <= mem[rd_ptr];
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = rv_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: FWFT and registered-read instances, queue model,
// directed scenarios with literal expectations, then random traffic.
module tb_fifo_flex;

  localparam int DW = 8;
  localparam int DP = 6;
  localparam int CW = $clog2(DP+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] afull_thr = 3'd4;
  logic [CW-1:0] aempty_thr = 3'd1;

  logic          a_full, a_empty, a_rv, a_af, a_ae, a_ov, a_un;
  logic [DW-1:0] a_rd;
  logic [CW-1:0] a_cnt;
  logic          b_full, b_empty, b_rv, b_af, b_ae, b_ov, b_un;
  logic [DW-1:0] b_rd;
  logic [CW-1:0] b_cnt;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b1)) u_a (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .full(a_full),
    .rd_en(rd_en), .rd_data(a_rd), .rd_valid(a_rv),
    .empty(a_empty), .count(a_cnt),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .almost_full(a_af), .almost_empty(a_ae),
    .flush(flush), .clr_err(clr_err),
    .overflow(a_ov), .underflow(a_un)
  );

  fifo_flex #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b0)) u_b (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .full(b_full),
    .rd_en(rd_en), .rd_data(b_rd), .rd_valid(b_rv),
    .empty(b_empty), .count(b_cnt),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .almost_full(b_af), .almost_empty(b_ae),
    .flush(flush), .clr_err(clr_err),
    .overflow(b_ov), .underflow(b_un)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags derived from its size
  logic [DW-1:0] q[$];
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_rv = 1'b0;
      m_rd = '0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DP);
      was_empty = (q.size() == 0);
      if (wr_en && was_full && !flush) m_ov = 1'b1;
      else if (clr_err)                m_ov = 1'b0;
      if (rd_en && was_empty && !flush) m_un = 1'b1;
      else if (clr_err)                 m_un = 1'b0;
      if (flush) begin
        q.delete();
        m_rv = 1'b0;
      end else begin
        if (rd_en && !was_empty) begin
          m_rd = q.pop_front();
          m_rv = 1'b1;
        end else begin
          m_rv = 1'b0;
        end
        if (wr_en && !was_full) q.push_back(wr_data);
      end
    end
  end

  always @(negedge clk) begin
    int c;
    c = q.size();
    if (run) begin
      chk("a_count", 32'(a_cnt), 32'(c));
      chk("b_count", 32'(b_cnt), 32'(c));
      chk("a_full", 32'(a_full), 32'(c == DP));
      chk("b_full", 32'(b_full), 32'(c == DP));
      chk("a_empty", 32'(a_empty), 32'(c == 0));
      chk("b_empty", 32'(b_empty), 32'(c == 0));
      chk("a_afull", 32'(a_af), 32'(c >= int'(afull_thr)));
      chk("b_afull", 32'(b_af), 32'(c >= int'(afull_thr)));
      chk("a_aempty", 32'(a_ae), 32'(c <= int'(aempty_thr)));
      chk("b_aempty", 32'(b_ae), 32'(c <= int'(aempty_thr)));
      chk("a_ovf", 32'(a_ov), 32'(m_ov));
      chk("b_ovf", 32'(b_ov), 32'(m_ov));
      chk("a_unf", 32'(a_un), 32'(m_un));
      chk("b_unf", 32'(b_un), 32'(m_un));
      chk("a_rvalid", 32'(a_rv), 32'(c != 0));
      if (c != 0) chk("a_rdata", 32'(a_rd), 32'(q[0]));
      chk("b_rvalid", 32'(b_rv), 32'(m_rv));
      chk("b_rdata", 32'(b_rd), 32'(m_rd));
    end
  end

  // Drive one cycle; returns 1 time unit after the rising edge
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re,
                      input bit fl, input bit ce);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    flush = fl;
    clr_err = ce;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_empty", 32'(b_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_bvalid", 32'(b_rv), 32'd0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);

    for (int i = 1; i <= 6; i++) step(1, DW'(i), 0, 0, 0);
    chk("fill_full", 32'(a_full), 32'd1);
    chk("fill_count", 32'(a_cnt), 32'd6);
    for (int i = 1; i <= 6; i++) begin
      chk("seq_a", 32'(a_rd), 32'(i));
      step(0, 0, 1, 0, 0);
      chk("seq_b", 32'(b_rd), 32'(i));
      chk("seq_bv", 32'(b_rv), 32'd1);
    end
    chk("drain_empty", 32'(a_empty), 32'd1);
    for (int i = 7; i <= 9; i++) step(1, DW'(i), 0, 0, 0);
    for (int i = 7; i <= 9; i++) begin
      chk("wrap_a", 32'(a_rd), 32'(i));
      step(0, 0, 1, 0, 0);
    end

    for (int i = 0; i < 6; i++) step(1, DW'(8'h10 + i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    chk("ovf_count", 32'(a_cnt), 32'd5);
    chk("ovf_set", 32'(a_ov), 32'd1);
    chk("ovf_head", 32'(a_rd), 32'h11);
    step(0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(a_ov), 32'd0);
    step(1, 8'h60, 0, 0, 0);
    step(1, 8'h66, 0, 0, 1);
    chk("ovf_setwins", 32'(b_ov), 32'd1);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    step(1, 8'hA5, 1, 0, 0);
    chk("unf_set", 32'(a_un), 32'd1);
    chk("unf_count", 32'(a_cnt), 32'd1);
    chk("unf_data", 32'(a_rd), 32'hA5);
    step(0, 0, 1, 0, 0);
    chk("unf_bdata", 32'(b_rd), 32'hA5);
    step(0, 0, 0, 0, 1);

    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    chk("lat_pre", 32'(b_rv), 32'd0);
    step(0, 0, 1, 0, 0);
    chk("lat_v1", 32'(b_rv), 32'd1);
    chk("lat_d1", 32'(b_rd), 32'h11);
    step(0, 0, 0, 0, 0);
    chk("lat_v0", 32'(b_rv), 32'd0);
    chk("lat_hold", 32'(b_rd), 32'h11);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("lat_d2", 32'(b_rd), 32'h22);
    step(0, 0, 0, 0, 0);
    chk("lat_hold2", 32'(b_rd), 32'h22);
    chk("lat_v2", 32'(b_rv), 32'd0);

    chk("thr_ae0", 32'(a_ae), 32'd1);
    chk("thr_af0", 32'(a_af), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step(1, DW'(8'h30 + c), 0, 0, 0);
      chk("thr_ae", 32'(a_ae), 32'(c <= 1));
      chk("thr_af", 32'(a_af), 32'(c >= 4));
    end
    afull_thr = 3'd7;
    #1;
    chk("thr_af7", 32'(a_af), 32'd0);
    step(1, 8'h36, 0, 0, 0);
    chk("thr_full7", 32'(b_af), 32'd0);
    afull_thr = 3'd0;
    #1;
    chk("thr_af_zero", 32'(a_af), 32'd1);
    afull_thr = 3'd4;
    step(1, 8'h99, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("fl_pre", 32'(a_cnt), 32'd4);
    step(1, 8'h77, 0, 1, 0);
    chk("fl_count", 32'(a_cnt), 32'd0);
    chk("fl_empty", 32'(b_empty), 32'd1);
    chk("fl_ovf", 32'(a_ov), 32'd1);
    chk("fl_unf", 32'(a_un), 32'd0);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) step(1, DW'(8'h40 + i), 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(a_cnt), 32'd0);
    chk("arst_empty", 32'(b_empty), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      afull_thr  = CW'($urandom_range(0, 7));
      aempty_thr = CW'($urandom_range(0, 7));
      step(($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 45,
           ($urandom % 100) < 2, ($urandom % 100) < 5);
    end

    @(posedge clk);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised successor to the team's single-clock FIFO: any depth (including non-power-of-two), selectable first-word-fall-through (FWFT) or registered-read mode, a live occupancy count, and runtime-programmable almost-full/almost-empty thresholds. It also adds sticky overflow/underflow error flags and a synchronous flush. It sits between request producers and the cache controller pipelines, and is the drop-in buffer for new datapaths.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)
FWFT, 1, 1 = head word visible combinationally on rd_data; 0 = registered read with 1-cycle latency
CNT_W, $clog2(DEPTH+1), width of count and thresholds (derived; do not override)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_data  in  DATA_W  write word
full  out  1  count == DEPTH
rd_en  in  1  read request
rd_data  out  DATA_W  read word
rd_valid  out  1  rd_data is valid (see Behaviour)
empty  out  1  count == 0
count  out  CNT_W  current occupancy, 0..DEPTH
afull_thr  in  CNT_W  almost-full threshold
aempty_thr  in  CNT_W  almost-empty threshold
almost_full  out  1  count >= afull_thr
almost_empty  out  1  count <= aempty_thr
flush  in  1  synchronous clear of contents
clr_err  in  1  clears sticky error flags
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset==0, asynchronous): wr_ptr, rd_ptr and count = 0; overflow, underflow and rd_valid(FWFT=0) = 0; registered rd_data = 0. Hence empty=1, full=0. Storage array is not reset. Reset asserted mid-operation discards all contents immediately.
- Pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1. No power-of-two assumption is allowed.
- Write accepted (wa) = wr_en && !full && !flush: mem[wr_ptr] <= wr_data, then wr_ptr advances.
- Read accepted (ra) = rd_en && !empty && !flush: rd_ptr advances.
- count next = count + wa - ra. Simultaneous wa and ra leave count unchanged.
- Write while full is rejected, even with a concurrent accepted read. Read while empty is rejected, even with a concurrent write. A word is never readable in the cycle it is written.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = !empty.
  - rd_en acts as "pop the displayed word".
- FWFT=0:
  - On ra, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is exactly 1 cycle.
- Flags full, empty, almost_full and almost_empty are combinational from registered count and the threshold inputs. Threshold changes take effect in the same cycle. With afull_thr=0, almost_full is constantly 1.
- Error flags:
  - overflow sets on (wr_en && full && !flush).
  - underflow sets on (rd_en && empty && !flush).
  - Both hold until clr_err.
  - If clr_err and a new error occur in the same cycle, set wins.
  - Errors never alter pointers, count or data.
- flush (synchronous, one cycle):
  - Pointers and count go to 0; rd_valid <= 0.
  - wr_en and rd_en are ignored in that cycle.
  - Error flags are unaffected.
  - Storage is not cleared.

Test Plan:
- DEPTH=6, FWFT=1: write 0x01..0x06 -> full=1, count=6. Read 6 words -> data 0x01..0x06 in order, empty=1. Write 3 more and read them back -> pointer wrap 5->0 verified, data 0x07..0x09.
- Full, then wr_en=1 with rd_en=1 -> head word popped, write rejected, count=5, overflow=1. clr_err -> overflow=0. clr_err plus another overflow in the same cycle -> overflow stays 1.
- Empty, then rd_en=1 and wr_en=1 (data 0xA5) -> read rejected, underflow=1, count=1. Next cycle rd_data=0xA5.
- FWFT=0: write 0x11, 0x22; pulse rd_en at cycle T -> rd_valid=1 and rd_data=0x11 at T+1 only. rd_en at T+3 -> 0x22 at T+4. rd_data holds 0x22 afterward with rd_valid=0.
- afull_thr=4, aempty_thr=1: fill 0..6 -> almost_empty=1 at count<=1, almost_full=1 from count=4. Change afull_thr to 7 at count=5 -> almost_full drops to 0 the same cycle.
- Count=4, pulse flush with wr_en=1 -> count=0, empty=1, overflow/underflow unchanged. Separately, assert reset asynchronously mid-clock at count=3 -> empty=1 and count=0 before the next edge.
